// File: rtl/timer_trigger_ctrl.sv
// timer_trigger_ctrl: arm/trigger front end for the down-counting timer.
// Issues a load pulse, prescaled ticks and a completion pulse per run.
module timer_trigger_ctrl #(
  parameter int PRESCALE_W = 16,
  parameter int N_W        = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  arm_i,
  input  logic                  disarm_i,
  input  logic                  auto_rearm_i,
  input  logic                  trig_i,
  input  logic                  trig_edge_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [N_W-1:0]        n_i,
  input  logic                  done_i,
  output logic                  start_o,
  output logic                  tick_o,
  output logic [N_W-1:0]        n_o,
  output logic                  done_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      run_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  trig_d_q;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] reload_q, reload_d;
  logic [1:0]            blank_q, blank_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [N_W-1:0]        left_q, left_d;
  logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
  logic                  start_q, start_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;

  logic                  edge_evt;
  logic                  done_qual;
  logic                  presc_hit;
  logic                  runs_left;

  assign edge_evt  = trig_edge_i ? (~trig_i & trig_d_q)
                                 : (trig_i & ~trig_d_q);
  assign done_qual = done_i & (blank_q == 2'd0);
  assign presc_hit = (presc_q == reload_q);
  assign runs_left = (left_q != '0);

  assign start_o   = start_q;
  assign tick_o    = tick_q;
  assign n_o       = n_q;
  assign done_o    = done_q;
  assign state_o   = state_q;
  assign run_cnt_o = run_cnt_q;

  // state, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      trig_d_q  <= 1'b0;
      presc_q   <= '0;
      reload_q  <= '0;
      blank_q   <= 2'd0;
      n_q       <= '0;
      left_q    <= '0;
      run_cnt_q <= '0;
      start_q   <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_d_q  <= trig_i;
      presc_q   <= presc_d;
      reload_q  <= reload_d;
      blank_q   <= blank_d;
      n_q       <= n_d;
      left_q    <= left_d;
      run_cnt_q <= run_cnt_d;
      start_q   <= start_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  // next state: disarm wins, then per-state arm/trigger/run/complete
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    reload_d  = reload_q;
    blank_d   = blank_q;
    n_d       = n_q;
    left_d    = left_q;
    run_cnt_d = run_cnt_q;
    start_d   = 1'b0;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    if (disarm_i) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (edge_evt) begin
            state_d  = RUNNING;
            n_d      = n_i;
            left_d   = n_i;
            reload_d = prescale_i;
            presc_d  = '0;
            blank_d  = 2'd2;
            start_d  = 1'b1;
          end
        end
        RUNNING: begin
          if (blank_q != 2'd0) begin
            blank_d = blank_q - 2'd1;
          end
          if (done_qual) begin
            state_d = DONE;
            done_d  = 1'b1;
            presc_d = '0;
            if (run_cnt_q != {CNT_W{1'b1}}) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else if (presc_hit) begin
            presc_d = '0;
            if (runs_left) begin
              tick_d = 1'b1;
              left_d = left_q - 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        DONE: begin
          state_d = auto_rearm_i ? ARMED : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_trigger_ctrl.sv
// tb_timer_trigger_ctrl: directed and random runs against a schedule model.
// A small timer model closes the loop from start/tick back to done_i.
module tb_timer_trigger_ctrl;

  localparam int PW = 16;
  localparam int NW = 32;
  localparam int CW = 16;

  logic          clk    = 1'b0;
  logic          rstn   = 1'b0;
  logic          arm    = 1'b0;
  logic          disarm = 1'b0;
  logic          rearm  = 1'b0;
  logic          trig   = 1'b0;
  logic          tedge  = 1'b0;
  logic [PW-1:0] presc  = '0;
  logic [NW-1:0] nval   = '0;
  logic          done_i;
  logic          start_o;
  logic          tick_o;
  logic          done_o;
  logic [NW-1:0] n_o;
  logic [1:0]    state_o;
  logic [CW-1:0] run_cnt_o;
  logic [NW-1:0] tcnt;

  always #5 clk = ~clk;

  timer_trigger_ctrl #(
    .PRESCALE_W(PW),
    .N_W       (NW),
    .CNT_W     (CW)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .arm_i       (arm),
    .disarm_i    (disarm),
    .auto_rearm_i(rearm),
    .trig_i      (trig),
    .trig_edge_i (tedge),
    .prescale_i  (presc),
    .n_i         (nval),
    .done_i      (done_i),
    .start_o     (start_o),
    .tick_o      (tick_o),
    .n_o         (n_o),
    .done_o      (done_o),
    .state_o     (state_o),
    .run_cnt_o   (run_cnt_o)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) tcnt <= '0;
    else if (start_o) tcnt <= n_o;
    else if (tick_o && tcnt != '0) tcnt <= tcnt - 1'b1;
  end
  assign done_i = (tcnt == '0);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  longint        cyc     = 0;
  longint        rs      = 0;
  longint        da      = 0;
  longint        mP      = 0;
  longint        mN      = 0;
  int            phase   = 0;
  bit            m_run   = 1'b0;
  bit            m_trg   = 1'b0;
  logic [NW-1:0] m_n     = '0;
  logic [CW-1:0] m_cnt   = '0;

  int     obs_tick  = 0;
  int     obs_done  = 0;
  int     obs_start = 0;
  longint st_cyc    = 0;
  longint dn_cyc    = 0;
  longint tk_cyc    = -1;
  longint tk_gap    = 0;

  task automatic model_reset();
    phase = 0;
    m_run = 1'b0;
    m_trg = 1'b0;
    m_n   = '0;
    m_cnt = '0;
  endtask

  task automatic model_step();
    bit evt;
    cyc++;
    if (!rstn) begin
      model_reset();
      return;
    end
    evt = tedge ? (!trig && m_trg) : (trig && !m_trg);
    m_trg = trig;
    if (disarm) begin
      phase = 0;
      m_run = 1'b0;
    end else if (m_run) begin
      if (cyc == da + 1) begin
        m_run = 1'b0;
        phase = rearm ? 1 : 0;
      end
    end else if (phase == 0) begin
      if (arm) phase = 1;
    end else if (evt) begin
      m_run = 1'b1;
      rs    = cyc;
      mP    = longint'(presc);
      mN    = longint'(nval);
      m_n   = nval;
      if (mN == 0) da = rs + 3;
      else da = rs + 1 + mP + (mN - 1) * (mP + 1) + 2;
    end
    if (m_run && cyc == da && m_cnt != '1) m_cnt++;
  endtask

  task automatic compare();
    logic [1:0] es;
    bit est, etk, edn;
    longint j;
    es  = 2'(phase);
    est = 1'b0;
    etk = 1'b0;
    edn = 1'b0;
    if (m_run) begin
      es  = (cyc == da) ? 2'd3 : 2'd2;
      est = (cyc == rs);
      edn = (cyc == da);
      j   = cyc - (rs + 1 + mP);
      etk = (j >= 0) && (j % (mP + 1) == 0)
            && (j / (mP + 1) < mN);
    end
    if (tick_o === 1'b1) begin
      if (tk_cyc >= 0) tk_gap = cyc - tk_cyc;
      tk_cyc = cyc;
      obs_tick++;
    end
    if (start_o === 1'b1) begin
      st_cyc = cyc;
      obs_start++;
    end
    if (done_o === 1'b1) begin
      dn_cyc = cyc;
      obs_done++;
    end
    check("state", 64'(state_o), 64'(es));
    check("start", 64'(start_o), 64'(est));
    check("tick", 64'(tick_o), 64'(etk));
    check("done", 64'(done_o), 64'(edn));
    check("n_o", 64'(n_o), 64'(m_n));
    check("run_cnt", 64'(run_cnt_o), 64'(m_cnt));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_o !== 1'b1 && i < budget) begin
      cycle();
      i++;
    end
    check("wait_done", 64'(done_o), 64'd1);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  int b_tick, b_done, b_start;

  initial begin
    repeat (2) cycle();
    rstn = 1'b1;

    tedge = 1'b0; trig = 1'b0;
    nval = 5; presc = 3;
    cycle();
    arm_pulse();
    cycle();
    b_tick = obs_tick; b_done = obs_done; tk_cyc = -1;
    trig = 1'b1;
    cycle();
    nval = 32'h1234; presc = 7;
    wait_done(100);
    check("s2_ticks", 64'(obs_tick - b_tick), 64'd5);
    check("s2_space", 64'(tk_gap), 64'd4);
    check("s2_tail", 64'(dn_cyc - tk_cyc), 64'd2);
    check("s2_cnt", 64'(run_cnt_o), 64'd1);
    cycle();
    check("s2_idle", 64'(state_o), 64'd0);

    tedge = 1'b1; nval = 0; presc = 0;
    cycle();
    arm_pulse();
    cycle();
    b_tick = obs_tick;
    trig = 1'b0;
    cycle();
    wait_done(20);
    check("s3_gap", 64'(dn_cyc - st_cyc), 64'd3);
    check("s3_ticks", 64'(obs_tick - b_tick), 64'd0);
    cycle();

    tedge = 1'b0; rearm = 1'b1;
    nval = 2; presc = 1;
    arm_pulse();
    cycle();
    b_start = obs_start;
    for (int r = 0; r < 3; r++) begin
      trig = 1'b1;
      cycle();
      cycle();
      trig = 1'b0;
      cycle();
      trig = 1'b1;
      cycle();
      wait_done(60);
      cycle();
      check("s4_armed", 64'(state_o), 64'd1);
      trig = 1'b0;
      cycle();
    end
    check("s4_starts", 64'(obs_start - b_start), 64'd3);
    check("s4_runs", 64'(run_cnt_o), 64'd5);
    rearm = 1'b0;
    disarm = 1'b1;
    cycle();
    disarm = 1'b0;

    nval = 10; presc = 1;
    arm_pulse();
    b_tick = obs_tick; b_done = obs_done;
    trig = 1'b1;
    cycle();
    begin
      int i = 0;
      while (obs_tick - b_tick < 2 && i < 60) begin
        cycle();
        i++;
      end
    end
    check("s5_tick2", 64'(tick_o), 64'd1);
    disarm = 1'b1;
    cycle();
    disarm = 1'b0;
    check("s5_stop", 64'(tick_o), 64'd0);
    check("s5_idle", 64'(state_o), 64'd0);
    repeat (6) cycle();
    check("s5_nodone", 64'(obs_done - b_done), 64'd0);
    check("s5_cnt", 64'(run_cnt_o), 64'd5);

    b_start = obs_start;
    cycle();
    arm_pulse();
    repeat (5) cycle();
    check("s6_nostart", 64'(obs_start - b_start), 64'd0);
    check("s6_armed", 64'(state_o), 64'd1);
    disarm = 1'b1;
    cycle();
    disarm = 1'b0;
    force dut.run_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cycle();
    release dut.run_cnt_q;
    cycle();
    nval = 2; presc = 0;
    arm_pulse();
    trig = 1'b0;
    cycle();
    trig = 1'b1;
    cycle();
    wait_done(40);
    check("s6_sat", 64'(run_cnt_o), 64'hFFFF);
    cycle();

    nval = 3; presc = 2; trig = 1'b0;
    arm_pulse();
    trig = 1'b1;
    cycle();
    repeat (3) cycle();
    #2;
    rstn = 1'b0;
    #1;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_start", 64'(start_o), 64'd0);
    check("rst_tick", 64'(tick_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_n", 64'(n_o), 64'd0);
    check("rst_cnt", 64'(run_cnt_o), 64'd0);
    cycle();
    rstn = 1'b1;
    b_start = obs_start;
    trig = 1'b0;
    cycle();
    trig = 1'b1;
    cycle();
    repeat (3) cycle();
    check("rst_noarm", 64'(obs_start - b_start), 64'd0);

    for (int i = 0; i < 400; i++) begin
      arm    = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) trig = ~trig;
      if ($urandom_range(0, 49) == 0) tedge = ~tedge;
      if ($urandom_range(0, 29) == 0) rearm = ~rearm;
      presc = PW'($urandom_range(0, 3));
      nval  = NW'($urandom_range(0, 4));
      cycle();
    end
    arm = 1'b0;
    disarm = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
